// File: rtl/hazard_tag_pipe.sv
// -----------------------------------------------------------------------------
// hazard_tag_pipe
//
// Purpose:
//   Producer/consumer side of the data hazard detection unit. This block:
//   - Carries destination-register tags (RD, RF_LE, L) through the EX, MEM and
//     WB stages, and publishes them for the hazard unit to compare against.
//   - Takes the forwarding selects (A_S, B_S) from the hazard unit, muxes the
//     chosen operands and registers them into ID/EX.
//   - Inserts an EX bubble on a stall (NOP) or a squash (FLUSH).
//   - Drives the IF/ID load/clear controls.
//   - Keeps a saturating count of stall cycles.
//
// Ports:
//   clk                         pipeline clock, rising-edge active
//   rst_n                       synchronous active-low reset
//   ID_RD / ID_RF_LE / ID_L     destination tag, write enable and load flag of
//                               the instruction in ID
//   RA_VAL / RB_VAL             register-file read data
//   A_S / B_S                   forwarding selects
//                               (00 reg, 01 EX, 10 MEM, 11 WB)
//   NOP / LE                    stall request and ID load enable
//   FLUSH                       branch-taken squash of the ID instruction
//   EX_RESULT / MEM_RESULT /
//   WB_RESULT                   forwarding sources
//   EX_RD, MEM_RD, WB_RD        per-stage destination tags (registered)
//   EX_RF_LE, MEM_RF_LE,
//   WB_RF_LE                    per-stage write enables (registered)
//   EX_L                        EX-stage instruction is a load (registered)
//   EX_OPA / EX_OPB             registered EX operands
//   IFID_LE / IFID_CLR          IF/ID register controls (combinational)
//   STALL_CNT                   saturating stall-cycle counter (registered)
// -----------------------------------------------------------------------------
module hazard_tag_pipe #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,

  // ID-stage instruction fields
  input  logic [REG_W-1:0]  ID_RD,
  input  logic              ID_RF_LE,
  input  logic              ID_L,
  input  logic [DATA_W-1:0] RA_VAL,
  input  logic [DATA_W-1:0] RB_VAL,

  // Hazard unit controls
  input  logic [1:0]        A_S,
  input  logic [1:0]        B_S,
  input  logic              NOP,
  input  logic              LE,
  input  logic              FLUSH,

  // Forwarding sources
  input  logic [DATA_W-1:0] EX_RESULT,
  input  logic [DATA_W-1:0] MEM_RESULT,
  input  logic [DATA_W-1:0] WB_RESULT,

  // Stage tags
  output logic [REG_W-1:0]  EX_RD,
  output logic [REG_W-1:0]  MEM_RD,
  output logic [REG_W-1:0]  WB_RD,
  output logic              EX_RF_LE,
  output logic              MEM_RF_LE,
  output logic              WB_RF_LE,
  output logic              EX_L,

  // EX operands
  output logic [DATA_W-1:0] EX_OPA,
  output logic [DATA_W-1:0] EX_OPB,

  // IF/ID control and statistics
  output logic              IFID_LE,
  output logic              IFID_CLR,
  output logic [CNT_W-1:0]  STALL_CNT
);

  localparam logic [REG_W-1:0]  REG_ZERO  = {REG_W{1'b0}};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  // ---------------------------------------------------------------------------
  // Forwarding mux. Shared by both operand paths so A and B decode identically.
  // ---------------------------------------------------------------------------
  function automatic logic [DATA_W-1:0] fwd_mux(
    input logic [1:0]        sel,
    input logic [DATA_W-1:0] reg_val,
    input logic [DATA_W-1:0] ex_val,
    input logic [DATA_W-1:0] mem_val,
    input logic [DATA_W-1:0] wb_val
  );
    logic [DATA_W-1:0] res;
    case (sel)
      2'b00:   res = reg_val;
      2'b01:   res = ex_val;
      2'b10:   res = mem_val;
      2'b11:   res = wb_val;
      default: res = reg_val;
    endcase
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [REG_W-1:0]  ex_rd_q,     ex_rd_d;
  logic              ex_rf_le_q,  ex_rf_le_d;
  logic              ex_l_q,      ex_l_d;
  logic [DATA_W-1:0] ex_opa_q,    ex_opa_d;
  logic [DATA_W-1:0] ex_opb_q,    ex_opb_d;
  logic [REG_W-1:0]  mem_rd_q,    mem_rd_d;
  logic              mem_rf_le_q, mem_rf_le_d;
  logic [REG_W-1:0]  wb_rd_q,     wb_rd_d;
  logic              wb_rf_le_q,  wb_rf_le_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic              bubble_s;    // EX receives a bubble this edge
  logic              stall_inc_s; // a genuine stall cycle (flush wins over NOP)
  logic [DATA_W-1:0] opa_fwd_s;
  logic [DATA_W-1:0] opb_fwd_s;

  // Bubble/stall qualification and operand selection.
  always_comb begin
    bubble_s    = FLUSH | NOP;
    stall_inc_s = NOP & ~FLUSH;
    opa_fwd_s   = fwd_mux(A_S, RA_VAL, EX_RESULT, MEM_RESULT, WB_RESULT);
    opb_fwd_s   = fwd_mux(B_S, RB_VAL, EX_RESULT, MEM_RESULT, WB_RESULT);
  end

  // EX stage next state: bubble on flush/stall, otherwise the ID instruction.
  always_comb begin
    ex_rd_d    = REG_ZERO;
    ex_rf_le_d = 1'b0;
    ex_l_d     = 1'b0;
    ex_opa_d   = DATA_ZERO;
    ex_opb_d   = DATA_ZERO;
    if (bubble_s) begin
      ex_rd_d    = REG_ZERO;
      ex_rf_le_d = 1'b0;
      ex_l_d     = 1'b0;
      ex_opa_d   = DATA_ZERO;
      ex_opb_d   = DATA_ZERO;
    end else begin
      ex_rd_d    = ID_RD;
      // Writes to GR0 are discarded here, so GR0 can never match a forward.
      ex_rf_le_d = ID_RF_LE & (ID_RD != REG_ZERO);
      ex_l_d     = ID_L;
      ex_opa_d   = opa_fwd_s;
      ex_opb_d   = opb_fwd_s;
    end
  end

  // MEM and WB stages never stall: they shift unconditionally.
  always_comb begin
    mem_rd_d    = ex_rd_q;
    mem_rf_le_d = ex_rf_le_q;
    wb_rd_d     = mem_rd_q;
    wb_rf_le_d  = mem_rf_le_q;
  end

  // Stall counter next state, saturating at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_inc_s && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Pipeline tag, operand and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_rd_q     <= REG_ZERO;
      ex_rf_le_q  <= 1'b0;
      ex_l_q      <= 1'b0;
      ex_opa_q    <= DATA_ZERO;
      ex_opb_q    <= DATA_ZERO;
      mem_rd_q    <= REG_ZERO;
      mem_rf_le_q <= 1'b0;
      wb_rd_q     <= REG_ZERO;
      wb_rf_le_q  <= 1'b0;
      stall_cnt_q <= CNT_ZERO;
    end else begin
      ex_rd_q     <= ex_rd_d;
      ex_rf_le_q  <= ex_rf_le_d;
      ex_l_q      <= ex_l_d;
      ex_opa_q    <= ex_opa_d;
      ex_opb_q    <= ex_opb_d;
      mem_rd_q    <= mem_rd_d;
      mem_rf_le_q <= mem_rf_le_d;
      wb_rd_q     <= wb_rd_d;
      wb_rf_le_q  <= wb_rf_le_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. IF/ID controls are the only combinational outputs; a flush forces
  // a load so the squashed instruction is cleared rather than held.
  // ---------------------------------------------------------------------------
  assign IFID_LE   = LE | FLUSH;
  assign IFID_CLR  = FLUSH;

  assign EX_RD     = ex_rd_q;
  assign MEM_RD    = mem_rd_q;
  assign WB_RD     = wb_rd_q;
  assign EX_RF_LE  = ex_rf_le_q;
  assign MEM_RF_LE = mem_rf_le_q;
  assign WB_RF_LE  = wb_rf_le_q;
  assign EX_L      = ex_l_q;
  assign EX_OPA    = ex_opa_q;
  assign EX_OPB    = ex_opb_q;
  assign STALL_CNT = stall_cnt_q;

endmodule
